host_bus_bridge: RTL

//  Parametrised host-to-memory/register bridge; next generation of the top-level host access path.

---
 rtl/hb_pkg.sv | 24 ++
 rtl/hb_regfile.sv | 65 ++++++
 rtl/host_bus_bridge.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/hb_pkg.sv
// Shared encodings for the host bus bridge: host/memory op codes, register
// indices and STATUS/CTRL bit positions.
package hb_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam int REG_CTRL          = 0;
  localparam int REG_STATUS        = 1;
  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int STATUS_HALTED_BIT = 0;
  localparam int STATUS_ERR_BIT    = 1;

endpackage

// File: rtl/hb_regfile.sv
// Bridge register file: CTRL (core enable), STATUS (halted, sticky W1C error)
// and general-purpose scratch slots from index 2 upward.
module hb_regfile
  import hb_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] i_idx,
  input  logic [DATA_W-1:0]           i_wdata,
  input  logic                        i_err_set,
  input  logic                        i_core_halted,
  output logic [DATA_W-1:0]           o_rdata,
  output logic                        o_core_enable
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic              ctrl_en_reg;
  logic              err_reg;
  logic [DATA_W-1:0] scratch_reg [NUM_REGS];

  assign o_core_enable = ctrl_en_reg;

  always_comb begin
    o_rdata = '0;
    if (i_idx == IDX_W'(REG_CTRL)) begin
      o_rdata[CTRL_ENABLE_BIT] = ctrl_en_reg;
    end else if (i_idx == IDX_W'(REG_STATUS)) begin
      o_rdata[STATUS_HALTED_BIT] = i_core_halted;
      o_rdata[STATUS_ERR_BIT]    = err_reg;
    end else if (int'(i_idx) < NUM_REGS) begin
      o_rdata = scratch_reg[i_idx];
    end
  end

  // A W1C clear in the same edge as a new error leaves ERR cleared.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ctrl_en_reg <= 1'b0;
      err_reg     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        scratch_reg[i] <= '0;
      end
    end else begin
      if (i_wr_en && i_idx == IDX_W'(REG_CTRL)) begin
        ctrl_en_reg <= i_wdata[CTRL_ENABLE_BIT];
      end
      if (i_wr_en && i_idx == IDX_W'(REG_STATUS) && i_wdata[STATUS_ERR_BIT]) begin
        err_reg <= 1'b0;
      end else if (i_err_set) begin
        err_reg <= 1'b1;
      end
      for (int i = 2; i < NUM_REGS; i++) begin
        if (i_wr_en && int'(i_idx) == i) begin
          scratch_reg[i] <= i_wdata;
        end
      end
    end
  end

endmodule

// File: rtl/host_bus_bridge.sv
// Host access bridge: decodes host ops into the register file or memory port 0,
// hands all memory ports to the core when enabled, and waits out read latency.
module host_bus_bridge
  import hb_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int MEM_ADDR_W   = 13,
  parameter int NUM_PORTS    = 4,
  parameter int READ_LATENCY = 1,
  parameter int NUM_REGS     = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [1:0]                       i_op,
  input  logic [ADDR_W-1:0]                i_addr,
  input  logic [DATA_W-1:0]                i_wdata,
  output logic [DATA_W-1:0]                o_rdata,
  output logic                             o_pending,
  output logic                             o_ack,
  output logic                             o_core_enable,
  input  logic                             i_core_halted,
  input  logic [2*NUM_PORTS-1:0]           i_core_op,
  input  logic [MEM_ADDR_W*NUM_PORTS-1:0]  i_core_addr,
  input  logic [DATA_W*NUM_PORTS-1:0]      i_core_wdata,
  output logic [DATA_W*NUM_PORTS-1:0]      o_core_rdata,
  output logic [2*NUM_PORTS-1:0]           o_mem_op,
  output logic [MEM_ADDR_W*NUM_PORTS-1:0]  o_mem_addr,
  output logic [DATA_W*NUM_PORTS-1:0]      o_mem_wdata,
  input  logic [DATA_W*NUM_PORTS-1:0]      i_mem_rdata
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_e                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [1:0]            req_op_reg, req_op_next;
  logic [MEM_ADDR_W-1:0] req_addr_reg, req_addr_next;
  logic [DATA_W-1:0]     req_wdata_reg, req_wdata_next;
  logic [DATA_W-1:0]     rdata_reg, rdata_next;
  logic                  ack_reg, ack_next;
  logic                  reg_wr;
  logic                  err_set;
  logic [DATA_W-1:0]     reg_rdata;
  logic                  host_active;
  logic                  host_reg_space;
  logic                  unused_addr;

  assign host_active    = (i_op == OP_READ) || (i_op == OP_WRITE);
  assign host_reg_space = i_addr[ADDR_W-1];
  assign unused_addr    = ^i_addr;

  assign o_rdata      = rdata_reg;
  assign o_ack        = ack_reg;
  assign o_pending    = (state_reg != ST_IDLE);
  assign o_core_rdata = i_mem_rdata;

  hb_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_wr_en       (reg_wr),
    .i_idx         (i_addr[IDX_W-1:0]),
    .i_wdata       (i_wdata),
    .i_err_set     (err_set),
    .i_core_halted (i_core_halted),
    .o_rdata       (reg_rdata),
    .o_core_enable (o_core_enable)
  );

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    req_op_next    = req_op_reg;
    req_addr_next  = req_addr_reg;
    req_wdata_next = req_wdata_reg;
    rdata_next     = rdata_reg;
    ack_next       = 1'b0;
    reg_wr         = 1'b0;
    err_set        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (host_active) begin
          if (host_reg_space) begin
            reg_wr   = (i_op == OP_WRITE);
            ack_next = 1'b1;
            if (i_op == OP_READ) begin
              rdata_next = reg_rdata;
            end
          end else if (o_core_enable) begin
            err_set    = 1'b1;
            rdata_next = '0;
            ack_next   = 1'b1;
          end else begin
            req_op_next    = i_op;
            req_addr_next  = i_addr[MEM_ADDR_W-1:0];
            req_wdata_next = i_wdata;
            state_next     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        // Port 0 carries the request for this cycle only.
        err_set        = host_active;
        req_op_next    = OP_NOP;
        req_addr_next  = '0;
        req_wdata_next = '0;
        if (req_op_reg == OP_READ) begin
          state_next = ST_WAIT;
          cnt_next   = '0;
        end else begin
          state_next = ST_IDLE;
          ack_next   = 1'b1;
        end
      end
      ST_WAIT: begin
        err_set = host_active;
        if (cnt_reg == CNT_W'(READ_LATENCY - 1)) begin
          rdata_next = i_mem_rdata[DATA_W-1:0];
          ack_next   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      req_op_reg    <= OP_NOP;
      req_addr_reg  <= '0;
      req_wdata_reg <= '0;
      rdata_reg     <= '0;
      ack_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      req_op_reg    <= req_op_next;
      req_addr_reg  <= req_addr_next;
      req_wdata_reg <= req_wdata_next;
      rdata_reg     <= rdata_next;
      ack_reg       <= ack_next;
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    if (gi == 0) begin : g_host
      assign o_mem_op[1:0]              = o_core_enable ? i_core_op[1:0] : req_op_reg;
      assign o_mem_addr[MEM_ADDR_W-1:0] = o_core_enable ? i_core_addr[MEM_ADDR_W-1:0] : req_addr_reg;
      assign o_mem_wdata[DATA_W-1:0]    = o_core_enable ? i_core_wdata[DATA_W-1:0] : req_wdata_reg;
    end else begin : g_core_only
      assign o_mem_op[2*gi +: 2] = o_core_enable ? i_core_op[2*gi +: 2] : 2'b00;
      assign o_mem_addr[MEM_ADDR_W*gi +: MEM_ADDR_W] =
        o_core_enable ? i_core_addr[MEM_ADDR_W*gi +: MEM_ADDR_W] : '0;
      assign o_mem_wdata[DATA_W*gi +: DATA_W] =
        o_core_enable ? i_core_wdata[DATA_W*gi +: DATA_W] : '0;
    end
  end

endmodule
